// File: rtl/dmem_if.sv
// Request/response bundle between the pipeline memory stage and dmem_responder.
// Carries resp_err only when DMEM_ALIGN_CHECK_EN is defined.
interface dmem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  busy;
`ifdef DMEM_ALIGN_CHECK_EN
  logic                  resp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, busy, resp_err
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, busy, resp_err
  );
`else
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, busy
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, busy
  );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a LATENCY-cycle wait (1..15) and a
// one-cycle response pulse. Optional misalignment reporting via DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);
  localparam int NB     = DATA_W / 8;
  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WORD_W;
  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [3:0]        count_reg, count_next;
  logic              wr_reg;
  logic [WORD_W-1:0] word_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [NB-1:0]     be_reg;
  logic              accept;
  logic              commit;
  logic              misalign;
  logic [DATA_W-1:0] rdata_all;

  assign accept = (state_reg == ST_IDLE) && bus.req_valid;
  assign commit = (state_reg == ST_WAIT) && (count_reg == 4'd0);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_next = ST_WAIT;
          count_next = COUNT_INIT;
        end
      end
      ST_WAIT: begin
        if (count_reg == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Request fields are captured only on acceptance; pins are don't-care afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_reg    <= 1'b0;
      word_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
    end else if (accept) begin
      wr_reg    <= bus.req_wr;
      word_reg  <= bus.req_addr[ADDR_W-1:2];
      wdata_reg <= bus.req_wdata;
      be_reg    <= bus.req_be;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] low_reg;
  logic       resp_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      low_reg      <= 2'b00;
      resp_err_reg <= 1'b0;
    end else begin
      if (accept) begin
        low_reg <= bus.req_addr[1:0];
      end
      if (commit) begin
        resp_err_reg <= (low_reg != 2'b00);
      end
    end
  end

  assign misalign     = (low_reg != 2'b00);
  assign bus.resp_err = resp_err_reg;
`else
  assign misalign = 1'b0;
  wire unused_low_addr = &{1'b0, bus.req_addr[1:0]};
`endif

  // One narrow RAM per byte lane so byte-enabled stores map onto plain block RAM.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH];
    logic [7:0] rd_lane_reg;

    always_ff @(posedge clk) begin
      if (!rst && commit && wr_reg && be_reg[gi] && !misalign) begin
        mem_lane[word_reg] <= wdata_reg[8*gi +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_lane_reg <= 8'h00;
      end else if (commit && (misalign || !wr_reg)) begin
        rd_lane_reg <= misalign ? 8'h00 : mem_lane[word_reg];
      end
    end

    assign rdata_all[8*gi +: 8] = rd_lane_reg;
  end

  assign bus.resp_rdata = rdata_all;
  assign bus.req_ready  = (state_reg == ST_IDLE);
  assign bus.resp_valid = (state_reg == ST_RESP);
  assign bus.busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: timing, byte enables, back-to-back,
// reset mid-access, top word, and misalignment when DMEM_ALIGN_CHECK_EN is set.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  dmem_if #(.DATA_W(32), .ADDR_W(12)) bus ();

  dmem_responder #(.DATA_W(32), .ADDR_W(12), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Issues one request and watches LAT+3 cycles after the accepting edge.
  task automatic access(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int resp_k, output int pulses, output int busy_bad);
    int w;
    resp_k = -1; pulses = 0; busy_bad = 0; rdata = 32'hxxxxxxxx; err = 1'b0;
    @(negedge clk);
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    bus.req_wr = wr; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_be = be;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_addr = 12'hAAA; bus.req_wdata = 32'h0BAD0BAD; bus.req_be = 4'hF;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'(k <= LAT + 1)) busy_bad++;
      if (bus.resp_valid === 1'b1) begin
        pulses++;
        resp_k = k;
        rdata  = bus.resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
        err = bus.resp_err;
`endif
      end
    end
    $display("txn wr=%0d addr=%h wdata=%h be=%b -> resp_k=%0d pulses=%0d rdata=%h err=%0d",
             wr, addr, wdata, be, resp_k, pulses, rdata, err);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata); else pass_cnt++;
`ifdef DMEM_ALIGN_CHECK_EN
    total_cnt++; if (bus.resp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.resp_err); else pass_cnt++;
`endif
    rst = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int rk, np, bb;
    access(1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, rd, er, rk, np, bb);
    total_cnt++; if (rk !== LAT + 1) $display("FAIL store_resp_cycle: got %0d want %0d", rk, LAT + 1); else pass_cnt++;
    total_cnt++; if (np !== 1) $display("FAIL store_pulse_count: got %0d want 1", np); else pass_cnt++;
    total_cnt++; if (bb !== 0) $display("FAIL store_busy_window: got %0d bad cycles want 0", bb); else pass_cnt++;
    access(1'b0, 12'h010, 32'h0, 4'b0000, rd, er, rk, np, bb);
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL load_010: got %h want deadbeef", rd); else pass_cnt++;
    total_cnt++; if (rk !== LAT + 1 || bb !== 0) $display("FAIL load_timing: got k=%0d bad=%0d want k=%0d bad=0", rk, bb, LAT + 1); else pass_cnt++;
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int rk, np, bb;
    access(1'b1, 12'h020, 32'h11223344, 4'b1111, rd, er, rk, np, bb);
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL rdata_hold_after_store: got %h want deadbeef", rd); else pass_cnt++;
    access(1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, rd, er, rk, np, bb);
    access(1'b0, 12'h020, 32'h0, 4'b0000, rd, er, rk, np, bb);
    total_cnt++; if (rd !== 32'h11BB33DD) $display("FAIL byte_enable_merge: got %h want 11bb33dd", rd); else pass_cnt++;
    access(1'b1, 12'h020, 32'hFFFFFFFF, 4'b0000, rd, er, rk, np, bb);
    total_cnt++; if (np !== 1) $display("FAIL be0_pulse: got %0d want 1", np); else pass_cnt++;
    access(1'b0, 12'h020, 32'h0, 4'b0000, rd, er, rk, np, bb);
    total_cnt++; if (rd !== 32'h11BB33DD) $display("FAIL be0_unchanged: got %h want 11bb33dd", rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int acc0 = -1, acc1 = -1, p0 = -1, p1 = -1, np = 0, nacc = 0;
    logic [31:0] d0 = 32'h0;
    @(negedge clk);
    bus.req_wr = 1'b0; bus.req_addr = 12'h010; bus.req_be = 4'h0; bus.req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus.resp_valid === 1'b1) begin
        if (np == 0) begin p0 = k; d0 = bus.resp_rdata; end
        else p1 = k;
        np++;
      end
      if (bus.req_valid && bus.req_ready === 1'b1) begin
        if (nacc == 0) acc0 = k; else acc1 = k;
        nacc++;
      end
      @(negedge clk);
      if (nacc == 2) bus.req_valid = 1'b0;
    end
    $display("txn back_to_back acc=%0d,%0d pulses=%0d,%0d count=%0d", acc0, acc1, p0, p1, np);
    total_cnt++; if (acc0 !== 0) $display("FAIL b2b_accept0: got %0d want 0", acc0); else pass_cnt++;
    total_cnt++; if (acc1 !== LAT + 2) $display("FAIL b2b_accept1: got %0d want %0d", acc1, LAT + 2); else pass_cnt++;
    total_cnt++; if (p0 !== LAT + 1) $display("FAIL b2b_pulse0: got %0d want %0d", p0, LAT + 1); else pass_cnt++;
    total_cnt++; if (p1 !== 2 * LAT + 3) $display("FAIL b2b_pulse1: got %0d want %0d", p1, 2 * LAT + 3); else pass_cnt++;
    total_cnt++; if (np !== 2) $display("FAIL b2b_pulse_count: got %0d want 2", np); else pass_cnt++;
    total_cnt++; if (d0 !== 32'hDEADBEEF) $display("FAIL b2b_rdata: got %h want deadbeef", d0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int rk, np, bb, seen;
    access(1'b1, 12'h040, 32'h00000000, 4'b1111, rd, er, rk, np, bb);
    @(negedge clk);
    bus.req_wr = 1'b1; bus.req_addr = 12'h040; bus.req_wdata = 32'h00000055; bus.req_be = 4'b1111;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b want 1", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.resp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    $display("txn reset mid-wait, pulses after reset=%0d", seen);
    total_cnt++; if (seen !== 0) $display("FAIL mid_reset_no_pulse: got %0d want 0", seen); else pass_cnt++;
    access(1'b0, 12'h040, 32'h0, 4'b0000, rd, er, rk, np, bb);
    total_cnt++; if (rd !== 32'h00000000) $display("FAIL mid_reset_store_dropped: got %h want 00000000", rd); else pass_cnt++;
  endtask

  task automatic test_top_word();
    logic [31:0] rd; logic er; int rk, np, bb;
    access(1'b1, 12'hFFC, 32'hCAFEF00D, 4'b1111, rd, er, rk, np, bb);
    access(1'b0, 12'hFFC, 32'h0, 4'b0000, rd, er, rk, np, bb);
    total_cnt++; if (rd !== 32'hCAFEF00D) $display("FAIL top_word: got %h want cafef00d", rd); else pass_cnt++;
`ifndef DMEM_ALIGN_CHECK_EN
    access(1'b0, 12'hFFD, 32'h0, 4'b0000, rd, er, rk, np, bb);
    total_cnt++; if (rd !== 32'hCAFEF00D) $display("FAIL low_bits_ignored: got %h want cafef00d", rd); else pass_cnt++;
`endif
    access(1'b0, 12'h000, 32'h0, 4'b0000, rd, er, rk, np, bb);
    total_cnt++; if (rd === 32'hCAFEF00D) $display("FAIL no_alias_word0: got %h want not cafef00d", rd); else pass_cnt++;
  endtask

`ifdef DMEM_ALIGN_CHECK_EN
  task automatic test_align();
    logic [31:0] rd; logic er; int rk, np, bb;
    access(1'b1, 12'h012, 32'h12345678, 4'b1111, rd, er, rk, np, bb);
    total_cnt++; if (er !== 1'b1) $display("FAIL align_err: got %b want 1", er); else pass_cnt++;
    total_cnt++; if (rk !== LAT + 1 || np !== 1) $display("FAIL align_timing: got k=%0d n=%0d want k=%0d n=1", rk, np, LAT + 1); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL align_rdata_zero: got %h want 0", rd); else pass_cnt++;
    access(1'b0, 12'h010, 32'h0, 4'b0000, rd, er, rk, np, bb);
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL align_mem_unchanged: got %h want deadbeef", rd); else pass_cnt++;
    total_cnt++; if (er !== 1'b0) $display("FAIL align_err_clear: got %b want 0", er); else pass_cnt++;
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_back_to_back();
    test_reset_mid();
    test_top_word();
`ifdef DMEM_ALIGN_CHECK_EN
    test_align();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that sits on the far side of the pipeline's memory stage and serves its load/store requests.
- Accepts one request at a time over a valid/ready handshake.
- Models a configurable access latency with a countdown.
- Returns a one-cycle response pulse.
- Drives a busy flag that the pipeline uses as its stall source.

Parameters:
- DATA_W, 32, data word width in bits; byte enables are DATA_W/8 wide.
- ADDR_W, 12, byte-address width; memory depth is 2^(ADDR_W-2) words.
- LATENCY, 2, cycles spent in WAIT before the access commits; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- req_be  in  DATA_W/8  store byte enables; bit i covers byte i.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  load data; valid while resp_valid=1 for loads.
- busy  out  1  access in flight (state != IDLE).

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, busy=0, countdown=0, latched request fields=0. Memory array is not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid=1 at a posedge, latch wr/addr/wdata/be, load countdown=LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0; input pins are ignored.
  - If countdown != 0, decrement it.
  - If countdown == 0, commit the access and go to RESP.
    - Store: for each i with be[i]=1, mem[word][8i+7:8i] <= wdata byte i.
    - Load: resp_rdata <= mem[word].
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Next state is IDLE.
  - resp_rdata holds its last value after a store and after the pulse.
- Latency: if the request is accepted at the posedge ending cycle T, resp_valid is high during cycle T+LATENCY+1.
  - busy is high from cycle T+1 through T+LATENCY+1 inclusive.
- Throughput: one request per LATENCY+2 cycles. A request held valid during RESP is accepted on the first posedge back in IDLE.
- Word index is req_addr[ADDR_W-1:2]; req_addr[1:0] is ignored unless the optional feature is enabled.
- Highest address 2^ADDR_W-4 is a legal access; no wrap logic is needed because the index is an exact width.
- A store with be=0 leaves memory unchanged but still produces resp_valid.
- Reset mid-operation (WAIT or RESP) returns to IDLE immediately:
  - No response pulse.
  - A store that has not yet committed is dropped.
- req_valid dropping after acceptance has no effect; the accepted request completes.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port resp_err (1 bit, reset 0), valid with resp_valid.
  - A request with req_addr[1:0] != 0 follows the same state and timing path, but at commit no store occurs and resp_rdata <= 0.
  - resp_err=1 for that response; 0 otherwise.
- Undefined: no resp_err port, and low address bits are silently ignored.

Test Plan:
- Reset, LATENCY=2: store 0xDEADBEEF to 0x010 with be=4'b1111 accepted at T -> busy high T+1..T+3, resp_valid pulse in T+3 only; a load from 0x010 then returns resp_rdata=0xDEADBEEF.
- Store 0x11223344 be=1111 to 0x020, then store 0xAABBCCDD be=0101 to 0x020 -> load 0x020 returns 0x11BB33DD.
- req_valid held high with two back-to-back loads -> first accepted at T, second accepted at T+4 (LATENCY=2); exactly two resp_valid pulses, at T+3 and T+7.
- Store 0x00000000 to 0x040, then store 0x55 to 0x040 with rst asserted during its WAIT -> no resp_valid; a later load of 0x040 returns 0x00000000; req_ready=1 the cycle after reset.
- Store 0xCAFEF00D to 0xFFC (top word) -> load 0xFFC returns 0xCAFEF00D. Without the feature, a load of 0xFFD also returns 0xCAFEF00D.
- DMEM_ALIGN_CHECK_EN defined: store 0x12345678 to 0x012 -> resp_err=1, resp_valid timing unchanged, and a load of 0x010 shows memory unchanged.
